ysyx_22050710_mem_stage: RTL and testbench

- Memory stage. Accepts one instruction at a time from the execute stage over a valid/allowin handshake and performs the load or store on a split-transaction data-memory port (address phase, then data phase).
- Drives the result to the write-back stage over a valid/allowin handshake. It is the sending end of the ms-to-ws bus.
- Exposes its pending destination registers to decode for hazard stalling.

---
 rtl/ysyx_22050710_mem_stage.sv | 141 ++++++++++++++
 tb/tb_ysyx_22050710_mem_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_mem_stage.sv
// Memory stage: valid/allowin handshake on both sides, split-transaction data-memory port.
// Optional result forwarding to decode is enabled with `define YSYX_22050710_MS_BYPASS_EN.
//
// state | meaning
// IDLE  | no instruction held
// ADDR  | address phase, request driven until addr_ok
// DATA  | waiting for data_ok (read data or write ack)
// DONE  | result presented to write-back until ws allowin
module ysyx_22050710_mem_stage #(
   parameter int WORD_WD         = 64,
   parameter int GPR_ADDR_WD     = 5,
   parameter int CSR_ADDR_WD     = 12,
   parameter int ES_TO_MS_BUS_WD = 280,
   parameter int MS_TO_WS_BUS_WD = 147
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] i_es_to_ms_bus,
   output logic                       o_ms_allowin,
   output logic                       o_ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] o_ms_to_ws_bus,
   input  logic                       i_ws_allowin,
   output logic [GPR_ADDR_WD-1:0]     o_ms_to_ds_gpr_rd,
   output logic [CSR_ADDR_WD-1:0]     o_ms_to_ds_csr_rd,
`ifdef YSYX_22050710_MS_BYPASS_EN
   output logic                       o_ms_fwd_valid,
   output logic [WORD_WD-1:0]         o_ms_fwd_data,
`endif
   output logic                       o_dmem_req,
   output logic                       o_dmem_we,
   output logic [WORD_WD-1:0]         o_dmem_addr,
   output logic [WORD_WD-1:0]         o_dmem_wdata,
   output logic [7:0]                 o_dmem_wmask,
   input  logic                       i_dmem_addr_ok,
   input  logic                       i_dmem_data_ok,
   input  logic [WORD_WD-1:0]         i_dmem_rdata
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t                     state;
   logic [ES_TO_MS_BUS_WD-1:0] es_q;
   logic [WORD_WD-1:0]         rdata_q;

   logic                   mem_ren, mem_wen, gpr_wen, csr_wen;
   logic [2:0]             mem_op;
   logic [WORD_WD-1:0]     mem_addr, mem_wdata, alu_result, csr_result;
   logic [GPR_ADDR_WD-1:0] rd;
   logic [CSR_ADDR_WD-1:0] csr;

   assign {mem_ren, mem_wen, mem_op, mem_addr, mem_wdata, gpr_wen, rd, alu_result,
           csr_wen, csr, csr_result} = es_q;

   logic accept, in_is_mem;
   assign o_ms_allowin = (state == IDLE) || (state == DONE && i_ws_allowin);
   assign accept       = i_es_to_ms_valid && o_ms_allowin;
   assign in_is_mem    = i_es_to_ms_bus[ES_TO_MS_BUS_WD-1] | i_es_to_ms_bus[ES_TO_MS_BUS_WD-2];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         es_q    <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               es_q  <= i_es_to_ms_bus;
               state <= in_is_mem ? ADDR : DONE;
            end
            ADDR: if (i_dmem_addr_ok) state <= DATA;
            DATA: if (i_dmem_data_ok) begin
               rdata_q <= i_dmem_rdata;
               state   <= DONE;
            end
            DONE: if (i_ws_allowin) begin
               if (i_es_to_ms_valid) begin
                  es_q  <= i_es_to_ms_bus;
                  state <= in_is_mem ? ADDR : DONE;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [2:0]         off;
   logic [5:0]         bit_off;
   logic [7:0]         base_mask;
   logic [WORD_WD-1:0] sh, load_data, gpr_final_result;

   assign off     = mem_addr[2:0];
   assign bit_off = {off, 3'b000};

   always_comb begin
      base_mask = 8'h01;
      case (mem_op[1:0])
         2'b00:   base_mask = 8'h01;
         2'b01:   base_mask = 8'h03;
         2'b10:   base_mask = 8'h0F;
         default: base_mask = 8'hFF;
      endcase
   end

   always_comb begin
      sh        = rdata_q >> bit_off;
      load_data = sh;
      case (mem_op)
         3'b000:  load_data = {{56{sh[7]}}, sh[7:0]};
         3'b001:  load_data = {{48{sh[15]}}, sh[15:0]};
         3'b010:  load_data = {{32{sh[31]}}, sh[31:0]};
         3'b100:  load_data = {56'b0, sh[7:0]};
         3'b101:  load_data = {48'b0, sh[15:0]};
         3'b110:  load_data = {32'b0, sh[31:0]};
         default: load_data = sh;
      endcase
   end

   assign gpr_final_result = mem_ren ? load_data : alu_result;

   // dmem outputs are gated so the port is quiet outside the address phase
   assign o_dmem_req   = (state == ADDR);
   assign o_dmem_we    = o_dmem_req & mem_wen;
   assign o_dmem_addr  = o_dmem_req ? {mem_addr[WORD_WD-1:3], 3'b000} : '0;
   assign o_dmem_wdata = o_dmem_req ? (mem_wdata << bit_off) : '0;
   assign o_dmem_wmask = o_dmem_req ? (base_mask << off) : 8'h00;

   assign o_ms_to_ws_valid = (state == DONE);
   assign o_ms_to_ws_bus   = {gpr_wen & ~mem_wen, rd, gpr_final_result, csr_wen, csr, csr_result};

   assign o_ms_to_ds_gpr_rd = (state != IDLE && gpr_wen) ? rd  : '0;
   assign o_ms_to_ds_csr_rd = (state != IDLE && csr_wen) ? csr : '0;

`ifdef YSYX_22050710_MS_BYPASS_EN
   assign o_ms_fwd_valid = (state == DONE) && gpr_wen;
   assign o_ms_fwd_data  = gpr_final_result;
`endif

endmodule

// File: tb/tb_ysyx_22050710_mem_stage.sv
// Directed bench for ysyx_22050710_mem_stage: non-memory op, loads, stalled store,
// write-back backpressure with zero-bubble handoff, and reset during the data phase.
module tb_ysyx_22050710_mem_stage;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_es_to_ms_valid;
   logic [279:0] i_es_to_ms_bus;
   logic         o_ms_allowin;
   logic         o_ms_to_ws_valid;
   logic [146:0] o_ms_to_ws_bus;
   logic         i_ws_allowin;
   logic [4:0]   o_ms_to_ds_gpr_rd;
   logic [11:0]  o_ms_to_ds_csr_rd;
   logic         o_dmem_req;
   logic         o_dmem_we;
   logic [63:0]  o_dmem_addr;
   logic [63:0]  o_dmem_wdata;
   logic [7:0]   o_dmem_wmask;
   logic         i_dmem_addr_ok;
   logic         i_dmem_data_ok;
   logic [63:0]  i_dmem_rdata;

   int total = 0;
   int bad   = 0;

   ysyx_22050710_mem_stage dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_es_to_ms_valid  (i_es_to_ms_valid),
      .i_es_to_ms_bus    (i_es_to_ms_bus),
      .o_ms_allowin      (o_ms_allowin),
      .o_ms_to_ws_valid  (o_ms_to_ws_valid),
      .o_ms_to_ws_bus    (o_ms_to_ws_bus),
      .i_ws_allowin      (i_ws_allowin),
      .o_ms_to_ds_gpr_rd (o_ms_to_ds_gpr_rd),
      .o_ms_to_ds_csr_rd (o_ms_to_ds_csr_rd),
      .o_dmem_req        (o_dmem_req),
      .o_dmem_we         (o_dmem_we),
      .o_dmem_addr       (o_dmem_addr),
      .o_dmem_wdata      (o_dmem_wdata),
      .o_dmem_wmask      (o_dmem_wmask),
      .i_dmem_addr_ok    (i_dmem_addr_ok),
      .i_dmem_data_ok    (i_dmem_data_ok),
      .i_dmem_rdata      (i_dmem_rdata)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [279:0] mk_es(input logic ren, input logic wen, input logic [2:0] op,
                                          input logic [63:0] addr, input logic [63:0] wdata,
                                          input logic gwen, input logic [4:0] rd,
                                          input logic [63:0] alu, input logic cwen,
                                          input logic [11:0] csr, input logic [63:0] cres);
      return {ren, wen, op, addr, wdata, gwen, rd, alu, cwen, csr, cres};
   endfunction

   task automatic chk(input string tag, input logic [146:0] obs, input logic [146:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic run_load(input string tag, input logic [63:0] addr, input logic [2:0] op,
                           input logic [63:0] rdata, input logic [63:0] exp);
      i_es_to_ms_bus   = mk_es(1'b1, 1'b0, op, addr, 64'h0, 1'b1, 5'd3, 64'h0, 1'b0, 12'h0, 64'h0);
      i_es_to_ms_valid = 1'b1;
      cyc();
      i_es_to_ms_valid = 1'b0;
      #1;
      chk({tag, "_req"},  o_dmem_req, 1'b1);
      chk({tag, "_addr"}, o_dmem_addr, {addr[63:3], 3'b000});
      chk({tag, "_we"},   o_dmem_we, 1'b0);
      i_dmem_addr_ok = 1'b1;
      cyc();
      i_dmem_addr_ok = 1'b0;
      #1;
      chk({tag, "_req_drop"}, o_dmem_req, 1'b0);
      chk({tag, "_novalid"},  o_ms_to_ws_valid, 1'b0);
      i_dmem_data_ok = 1'b1;
      i_dmem_rdata   = rdata;
      cyc();
      i_dmem_data_ok = 1'b0;
      i_dmem_rdata   = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      chk({tag, "_valid"},  o_ms_to_ws_valid, 1'b1);
      chk({tag, "_result"}, o_ms_to_ws_bus[140:77], exp);
      cyc();
      chk({tag, "_idle"}, o_ms_to_ws_valid, 1'b0);
   endtask

   logic [146:0] st_bus_exp;

   initial begin
      i_rst_n          = 1'b0;
      i_es_to_ms_valid = 1'b0;
      i_es_to_ms_bus   = '0;
      i_ws_allowin     = 1'b1;
      i_dmem_addr_ok   = 1'b0;
      i_dmem_data_ok   = 1'b0;
      i_dmem_rdata     = '0;
      #3;
      chk("rst_allowin", o_ms_allowin, 1'b1);
      chk("rst_valid",   o_ms_to_ws_valid, 1'b0);
      chk("rst_bus",     o_ms_to_ws_bus, '0);
      chk("rst_req",     o_dmem_req, 1'b0);
      chk("rst_wmask",   o_dmem_wmask, 8'h00);
      chk("rst_gpr_rd",  o_ms_to_ds_gpr_rd, 5'd0);
      cyc();
      i_rst_n = 1'b1;

      // non-memory add: valid one cycle after accept
      i_es_to_ms_bus   = mk_es(1'b0, 1'b0, 3'd0, 64'h0, 64'h0, 1'b1, 5'd5, 64'h1234,
                               1'b1, 12'h300, 64'hABCD);
      i_es_to_ms_valid = 1'b1;
      #1;
      chk("add_allowin", o_ms_allowin, 1'b1);
      chk("add_pre_valid", o_ms_to_ws_valid, 1'b0);
      cyc();
      i_es_to_ms_valid = 1'b0;
      #1;
      chk("add_valid",   o_ms_to_ws_valid, 1'b1);
      chk("add_result",  o_ms_to_ws_bus[140:77], 64'h1234);
      chk("add_rd",      o_ms_to_ws_bus[145:141], 5'd5);
      chk("add_gwen",    o_ms_to_ws_bus[146], 1'b1);
      chk("add_csr",     o_ms_to_ws_bus[76:0], {1'b1, 12'h300, 64'hABCD});
      chk("add_haz_gpr", o_ms_to_ds_gpr_rd, 5'd5);
      chk("add_haz_csr", o_ms_to_ds_csr_rd, 12'h300);
      chk("add_noreq",   o_dmem_req, 1'b0);
      cyc();
      chk("add_done",    o_ms_to_ws_valid, 1'b0);
      chk("add_haz_clr", o_ms_to_ds_gpr_rd, 5'd0);

      run_load("lb",  64'h0000_0000_0000_1003, 3'b000, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
      run_load("lbu", 64'h0000_0000_0000_1003, 3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
      run_load("lw",  64'h0000_0000_0000_1004, 3'b010, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
      run_load("lhu", 64'h0000_0000_0000_1002, 3'b101, 64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D);

      // sh at offset 6 with addr_ok held off for 4 cycles
      i_es_to_ms_bus   = mk_es(1'b0, 1'b1, 3'b001, 64'h0000_0000_0000_2006, 64'h0000_0000_0000_BEEF,
                               1'b1, 5'd9, 64'h2006, 1'b0, 12'h0, 64'h0);
      st_bus_exp       = {1'b0, 5'd9, 64'h2006, 1'b0, 12'h0, 64'h0};
      i_es_to_ms_valid = 1'b1;
      cyc();
      i_es_to_ms_valid = 1'b0;
      i_ws_allowin     = 1'b0;
      #1;
      chk("sh_we",    o_dmem_we, 1'b1);
      chk("sh_wmask", o_dmem_wmask, 8'hC0);
      chk("sh_wdata", o_dmem_wdata, 64'hBEEF_0000_0000_0000);
      chk("sh_addr",  o_dmem_addr, 64'h0000_0000_0000_2000);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("sh_stall_req",     o_dmem_req, 1'b1);
         chk("sh_stall_addr",    o_dmem_addr, 64'h0000_0000_0000_2000);
         chk("sh_stall_wmask",   o_dmem_wmask, 8'hC0);
         chk("sh_stall_allowin", o_ms_allowin, 1'b0);
         chk("sh_stall_valid",   o_ms_to_ws_valid, 1'b0);
      end
      i_dmem_addr_ok = 1'b1;
      i_dmem_data_ok = 1'b1;
      cyc();
      i_dmem_addr_ok = 1'b0;
      i_dmem_data_ok = 1'b0;
      #1;
      chk("sh_data_req", o_dmem_req, 1'b0);
      chk("sh_early_ok", o_ms_to_ws_valid, 1'b0);
      cyc();
      chk("sh_wait_data", o_ms_to_ws_valid, 1'b0);
      i_dmem_data_ok = 1'b1;
      cyc();
      i_dmem_data_ok = 1'b0;
      #1;
      chk("sh_valid", o_ms_to_ws_valid, 1'b1);
      chk("sh_gwen0", o_ms_to_ws_bus[146], 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_bus",     o_ms_to_ws_bus, st_bus_exp);
         chk("bp_valid",   o_ms_to_ws_valid, 1'b1);
         chk("bp_allowin", o_ms_allowin, 1'b0);
         cyc();
      end

      // write-back releases while a new instruction waits: zero-bubble handoff
      i_ws_allowin     = 1'b1;
      i_es_to_ms_bus   = mk_es(1'b0, 1'b0, 3'd0, 64'h0, 64'h0, 1'b1, 5'd7, 64'h55, 1'b0, 12'h0, 64'h0);
      i_es_to_ms_valid = 1'b1;
      #1;
      chk("b2b_allowin", o_ms_allowin, 1'b1);
      cyc();
      i_es_to_ms_valid = 1'b0;
      #1;
      chk("b2b_valid",  o_ms_to_ws_valid, 1'b1);
      chk("b2b_result", o_ms_to_ws_bus[140:77], 64'h55);
      chk("b2b_rd",     o_ms_to_ws_bus[145:141], 5'd7);
      cyc();
      chk("b2b_idle",   o_ms_to_ws_valid, 1'b0);

      // reset during the data phase drops the instruction
      i_es_to_ms_bus   = mk_es(1'b1, 1'b0, 3'b011, 64'h3000, 64'h0, 1'b1, 5'd4, 64'h0, 1'b0, 12'h0, 64'h0);
      i_es_to_ms_valid = 1'b1;
      cyc();
      i_es_to_ms_valid = 1'b0;
      i_dmem_addr_ok   = 1'b1;
      cyc();
      i_dmem_addr_ok   = 1'b0;
      #1;
      chk("rst_mid_data_allowin", o_ms_allowin, 1'b0);
      i_rst_n = 1'b0;
      #1;
      chk("rst_mid_allowin", o_ms_allowin, 1'b1);
      chk("rst_mid_valid",   o_ms_to_ws_valid, 1'b0);
      chk("rst_mid_haz",     o_ms_to_ds_gpr_rd, 5'd0);
      cyc();
      i_rst_n = 1'b1;
      cyc();
      i_dmem_data_ok = 1'b1;
      i_dmem_rdata   = 64'h1111_2222_3333_4444;
      cyc();
      i_dmem_data_ok = 1'b0;
      #1;
      chk("late_ok_valid",   o_ms_to_ws_valid, 1'b0);
      chk("late_ok_allowin", o_ms_allowin, 1'b1);
      cyc();
      chk("late_ok_valid2",  o_ms_to_ws_valid, 1'b0);
      chk("late_ok_req",     o_dmem_req, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
